alu_share_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared 32-bit four-function ALU (add/sub/and/or) in the MIPS datapath. It accepts operand/opcode requests from two clients, such as the execute stage and the address/branch unit. It grants one client at a time, drives the external ALU from registered operands for one full cycle, captures the result and returns it to the granted client with a valid/ready handshake.

---
 rtl/alu_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 14 +
 rtl/alu_share_arb.sv | 109 ++++++++++
 tb/tb_alu_share_arb.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU-sharing arbiter: opcodes, FSM encoding, client count.
package alu_arb_pkg;
  localparam int NUM_CLIENTS = 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational grant picker, round-robin on contention when rr_en is set,
// otherwise client 0 wins. Grant is one-hot, or zero when nothing is valid.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       rr_en,
  output logic [1:0] grant
);
  always_comb begin
    grant = valid;
    if (valid == 2'b11)
      grant = (rr_en && !last) ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/alu_share_arb.sv
// Arbiter/sequencer sharing one external 4-function ALU between two clients.
// Define ALU_ARB_RR_EN for round-robin on contention; default is fixed priority to client 0.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CLIENTS-1:0] req_valid,
  output logic [NUM_CLIENTS-1:0] req_ready,
  input  logic [WIDTH-1:0]       req0_a,
  input  logic [WIDTH-1:0]       req0_b,
  input  logic [1:0]             req0_op,
  input  logic [WIDTH-1:0]       req1_a,
  input  logic [WIDTH-1:0]       req1_b,
  input  logic [1:0]             req1_op,
  output logic [NUM_CLIENTS-1:0] rsp_valid,
  input  logic [NUM_CLIENTS-1:0] rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic                   alu_op1,
  output logic                   alu_op2,
  input  logic [WIDTH-1:0]       alu_result,
  output logic                   busy
);
  arb_state_t       state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic [1:0]       op_code;
  logic             owner;
  logic             last;
  logic             rr_en;
  logic [1:0]       gnt;
  logic             gidx;
  logic             accept;
  logic             done;

`ifdef ALU_ARB_RR_EN
  logic last_grant;
  assign rr_en = 1'b1;
  assign last  = last_grant;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    last_grant <= 1'b1;
    else if (done) last_grant <= owner;
`else
  assign rr_en = 1'b0;
  assign last  = 1'b1;
`endif

  rr_arb2 u_arb (
    .valid (req_valid),
    .last  (last),
    .rr_en (rr_en),
    .grant (gnt)
  );

  assign gidx = gnt[1];

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = gnt;
        accept    = |(req_valid & gnt);
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        done             = rsp_ready[owner];
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers feed the ALU directly, so its inputs move only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= OP_ADD;
      owner      <= 1'b0;
      rsp_result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a    <= gidx ? req1_a  : req0_a;
        op_b    <= gidx ? req1_b  : req0_b;
        op_code <= gidx ? req1_op : req0_op;
        owner   <= gidx;
      end
      if (state == EXEC) rsp_result <= alu_result;
    end
  end

  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_op1 = op_code[1];
  assign alu_op2 = op_code[0];
  assign busy    = (state != IDLE);
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb; models the external ALU.
module tb_alu_share_arb;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]       req0_op, req1_op;
  logic [WIDTH-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic             alu_op1, alu_op2, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .busy(busy)
  );

  // External ALU
  always_comb begin
    alu_result = '0;
    case ({alu_op1, alu_op2})
      2'b00: alu_result = alu_a + alu_b;
      2'b01: alu_result = alu_a - alu_b;
      2'b10: alu_result = alu_a & alu_b;
      2'b11: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One uncontested transaction on client c; caller leaves the FSM in IDLE.
  task automatic run1(input int c, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [31:0] exp, input string tag);
    logic [1:0] oh;
    oh = (c == 0) ? 2'b01 : 2'b10;
    if (c == 0) begin req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_a = a; req1_b = b; req1_op = op; end
    req_valid = oh;
    #1;
    chk({tag, "_rdy"}, req_ready, oh);
    step();
    req_valid = 2'b00;
    chk({tag, "_busy_exec"}, busy, 1);
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_rspv_exec"}, rsp_valid, 2'b00);
    step();
    chk({tag, "_rspv"}, rsp_valid, oh);
    chk({tag, "_res"}, rsp_result, exp);
    chk({tag, "_busy_resp"}, busy, 1);
    step();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [1:0] exp_g;
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b11;
    req0_a = '0; req0_b = '0; req0_op = 2'b00;
    req1_a = '0; req1_b = '0; req1_op = 2'b00;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_res", rsp_result, 0);
    chk("rst_alu", {alu_a, alu_b, alu_op1, alu_op2}, 0);
    chk("rst_rdy_none", req_ready, 2'b00);
    req_valid = 2'b01;
    #1;
    chk("rst_rdy_comb", req_ready, 2'b01);
    req_valid = 2'b00;
    #10 rst_n = 1'b1;
    step();

    run1(0, 32'd5, 32'd7, 2'b00, 32'd12, "add");
    run1(1, 32'd0, 32'd1, 2'b01, 32'hFFFF_FFFF, "subwrap");

    // Contention: both valid, grants observed over four transactions
    req0_a = 32'hF0F0; req0_b = 32'h0FF0; req0_op = 2'b10;
    req1_a = 32'hF000; req1_b = 32'h000F; req1_op = 2'b11;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      #1;
      chk($sformatf("cont_gnt%0d", i), req_ready, exp_g);
      step();
      step();
      chk($sformatf("cont_rspv%0d", i), rsp_valid, exp_g);
      chk($sformatf("cont_res%0d", i), rsp_result, (exp_g == 2'b01) ? 32'h00F0 : 32'hF00F);
      step();
    end

    // Backpressure on client 0 while client 1 waits
    req0_a = 32'd5; req0_b = 32'd3; req0_op = 2'b01;
    rsp_ready = 2'b10;
    #1;
    chk("bp_gnt", req_ready, 2'b01);
    step();
    req_valid = 2'b10;
    chk("bp_rdy_exec", req_ready, 2'b00);
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_v%0d", i), rsp_valid, 2'b01);
      chk($sformatf("bp_hold_r%0d", i), rsp_result, 32'd2);
      chk($sformatf("bp_hold_rdy%0d", i), req_ready, 2'b00);
      step();
    end
    rsp_ready = 2'b11;
    #1;
    chk("bp_rdy_resp", req_ready, 2'b00);
    step();
    chk("bp_c1_rdy", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    step();
    chk("bp_c1_res", rsp_result, 32'hF00F);
    chk("bp_c1_v", rsp_valid, 2'b10);
    step();

    // Asynchronous reset while in EXEC
    req0_a = 32'd1; req0_b = 32'd2; req0_op = 2'b00;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    chk("mid_in_exec", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_alu", {alu_a, alu_b, alu_op1, alu_op2}, 0);
    chk("mid_res", rsp_result, 0);
    chk("mid_rspv", rsp_valid, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid_norsp%0d", i), rsp_valid, 2'b00);
    end
    req_valid = 2'b11;
    #1;
    chk("mid_first_contest", req_ready, 2'b01);
    req_valid = 2'b00;

    run1(0, 32'hFF00FF00, 32'h0FF00FF0, 2'b00, 32'h0EF10EF0, "sw_add");
    run1(0, 32'hFF00FF00, 32'h0FF00FF0, 2'b01, 32'hEF10EF10, "sw_sub");
    run1(0, 32'hFF00FF00, 32'h0FF00FF0, 2'b10, 32'h0F000F00, "sw_and");
    run1(1, 32'hFF00FF00, 32'h0FF00FF0, 2'b11, 32'hFFF0FFF0, "sw_or");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
